// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared sizes and stack operation encoding for the RPN calculator datapath
package rpn_pkg;

  localparam int RPN_DATA_W      = 32;
  localparam int RPN_STACK_DEPTH = 32;
  localparam int RPN_PTR_W       = 6;

  typedef enum logic [1:0] {
    SOP_NOP,
    SOP_PUSH,
    SOP_POP,
    SOP_REPLACE
  } stack_op_e;

endpackage

// File: rtl/rpn_stack_regfile.sv
// rtl/rpn_stack_regfile.sv - operand storage, one synchronous write port and two asynchronous read ports
module rpn_stack_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is never reset; only entries below the pointer are ever observed.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/rpn_stack.sv
// rtl/rpn_stack.sv - RPN operand LIFO; define RPN_STACK_ERR_EN for sticky overflow/underflow flags
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int DATA_W = RPN_DATA_W,
  parameter int DEPTH  = RPN_STACK_DEPTH,
  parameter int PTR_W  = RPN_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
`ifdef RPN_STACK_ERR_EN
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [DATA_W-1:0] stack_top,
  output logic [DATA_W-1:0] stack_top_minus_one,
  output logic              full,
  output logic              empty,
  output logic [PTR_W-1:0]  stack_ptr
);

  localparam int AW = $clog2(DEPTH);

  stack_op_e         op;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  ptr_m1, ptr_m2;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign ptr_m1 = ptr_q - PTR_W'(1);
  assign ptr_m2 = ptr_q - PTR_W'(2);
  assign empty  = (ptr_q == '0);
  assign full   = (ptr_q == PTR_W'(DEPTH));

  // Decode the two strobes into one of four stack operations.
  always_comb begin
    op = SOP_NOP;
    unique case ({push, pop})
      2'b10:   op = SOP_PUSH;
      2'b01:   op = SOP_POP;
      2'b11:   op = SOP_REPLACE;
      default: op = SOP_NOP;
    endcase
  end

  // Next pointer and write port; guards keep the pointer inside 0..DEPTH.
  always_comb begin
    ptr_d = ptr_q;
    we    = 1'b0;
    waddr = ptr_q[AW-1:0];
    unique case (op)
      SOP_PUSH: begin
        if (!full) begin
          we    = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      SOP_POP: begin
        if (!empty) ptr_d = ptr_m1;
      end
      SOP_REPLACE: begin
        // An empty replace degenerates to a push into slot 0.
        we = 1'b1;
        if (empty) ptr_d = PTR_W'(1);
        else       waddr = ptr_m1[AW-1:0];
      end
      default: ;
    endcase
  end

  // Pointer register; reset empties the stack without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  rpn_stack_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_regfile (
    .clk    (clk),
    .we     (we && rst),
    .waddr  (waddr),
    .wdata  (data_in),
    .raddr0 (ptr_m1[AW-1:0]),
    .rdata0 (rdata0),
    .raddr1 (ptr_m2[AW-1:0]),
    .rdata1 (rdata1)
  );

  assign stack_top           = empty               ? '0 : rdata0;
  assign stack_top_minus_one = (ptr_q < PTR_W'(2)) ? '0 : rdata1;
  assign stack_ptr           = ptr_q;

`ifdef RPN_STACK_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // Sticky error flags; a new error on the same edge beats a clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (op == SOP_PUSH && full)  ovf_d = 1'b1;
    if (op == SOP_POP  && empty) unf_d = 1'b1;
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule
